// File: rtl/alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// alu_ctrl_seq
//
// Control sequencer for the A/Q/M register ALU datapath. It walks through
// add, subtract, Booth radix-2 multiply and non-restoring divide at any
// operand WIDTH. It emits one registered one-hot control strobe per cycle
// and owns the iteration counter.
//
// Parameters:
//   WIDTH        operand width in bits (>=2); multiply/divide iteration count
//   CNT_W        derived, width of the iteration counter
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   start        level request, only looked at while idle
//   opcode       00 add, 01 sub, 10 mul, 11 div; captured on entry to LOAD
//   q0, q_m1     Booth bit pair Q[0] / Q[-1] from the datapath
//   a_sign       sign bit of the datapath A register
//   divisor_zero M==0 flag from the datapath (divide-by-zero check only)
//   cs           one-hot strobes [0]LOAD [1]ADD [2]SUB [3]SHIFT [4]CORRECT
//                [5]OUTPUT [6]DECIDE [7]DONE; all zero while idle
//   cnt          current iteration index
//   busy         high in every state except idle
//   done         one-cycle completion pulse (same as cs[7])
//   err          divide-by-zero flag
//
// Build option:
//   DIV0_CHECK_EN  when defined, a divide with divisor_zero=1 seen in LOAD
//                  jumps straight to DONE and raises err. When undefined,
//                  divisor_zero is ignored and err is constant 0.
// ---------------------------------------------------------------------------
module alu_ctrl_seq #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       opcode,
  input  logic             q0,
  input  logic             q_m1,
  input  logic             a_sign,
  input  logic             divisor_zero,
  output logic [7:0]       cs,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD    = 4'd1,
    S_ADD     = 4'd2,
    S_SUB     = 4'd3,
    S_SHIFT   = 4'd4,
    S_CORRECT = 4'd5,
    S_OUTPUT  = 4'd6,
    S_DECIDE  = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [7:0]       cs_q, cs_d;
  logic             busy_q, busy_d;

`ifdef DIV0_CHECK_EN
  logic             err_q, err_d;
`else
  logic             div0_unused;
  assign div0_unused = divisor_zero;
`endif

  // State register. The strobes and busy are registered from the next
  // state, so they line up exactly with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
      cs_q    <= '0;
      busy_q  <= 1'b0;
`ifdef DIV0_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
`ifdef DIV0_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next-state logic. The counter only advances when it has not yet
  // reached the last iteration, so it never wraps. Multiply counts at the
  // SHIFT->DECIDE step; divide counts at the ADD/SUB->SHIFT step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
`ifdef DIV0_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          op_d    = opcode;
`ifdef DIV0_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        case (op_q)
          OP_ADD:  state_d = S_ADD;
          OP_SUB:  state_d = S_SUB;
          OP_MUL:  state_d = S_DECIDE;
          default: state_d = S_SHIFT;
        endcase
`ifdef DIV0_CHECK_EN
        if (op_q == OP_DIV && divisor_zero) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
`endif
      end
      S_ADD, S_SUB: begin
        if (op_q == OP_DIV) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_DECIDE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_SHIFT;
          end
        end else if (op_q == OP_MUL) begin
          state_d = S_SHIFT;
        end else begin
          state_d = S_OUTPUT;
        end
      end
      S_SHIFT: begin
        if (op_q == OP_MUL) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_OUTPUT;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_DECIDE;
          end
        end else begin
          state_d = a_sign ? S_ADD : S_SUB;
        end
      end
      S_DECIDE: begin
        if (op_q == OP_MUL) begin
          case ({q0, q_m1})
            2'b10:   state_d = S_SUB;
            2'b01:   state_d = S_ADD;
            default: state_d = S_SHIFT;
          endcase
        end else begin
          state_d = a_sign ? S_CORRECT : S_OUTPUT;
        end
      end
      S_CORRECT: state_d = S_OUTPUT;
      S_OUTPUT:  state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state into one-hot strobes.
  always_comb begin
    cs_d = '0;
    case (state_d)
      S_LOAD:    cs_d[0] = 1'b1;
      S_ADD:     cs_d[1] = 1'b1;
      S_SUB:     cs_d[2] = 1'b1;
      S_SHIFT:   cs_d[3] = 1'b1;
      S_CORRECT: cs_d[4] = 1'b1;
      S_OUTPUT:  cs_d[5] = 1'b1;
      S_DECIDE:  cs_d[6] = 1'b1;
      S_DONE:    cs_d[7] = 1'b1;
      default:   cs_d    = '0;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign cs   = cs_q;
  assign cnt  = cnt_q;
  assign busy = busy_q;
  assign done = cs_q[7];
`ifdef DIV0_CHECK_EN
  assign err  = err_q;
`else
  assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl_seq
//
// Bench for alu_ctrl_seq. Each operation is first expanded into the list of
// strobes the sequencer should show cycle by cycle, together with the
// datapath flags to present on those cycles. The DUT is then driven from
// that list and compared on the falling edge. A second WIDTH=16 instance
// covers the wider multiply.
// ---------------------------------------------------------------------------
module tb_alu_ctrl_seq;

  localparam int W  = 8;
  localparam int CW = $clog2(W);

  localparam logic [7:0] CS_LOAD    = 8'h01;
  localparam logic [7:0] CS_ADD     = 8'h02;
  localparam logic [7:0] CS_SUB     = 8'h04;
  localparam logic [7:0] CS_SHIFT   = 8'h08;
  localparam logic [7:0] CS_CORRECT = 8'h10;
  localparam logic [7:0] CS_OUTPUT  = 8'h20;
  localparam logic [7:0] CS_DECIDE  = 8'h40;
  localparam logic [7:0] CS_DONE    = 8'h80;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          start16;
  logic [1:0]    opcode;
  logic          q0;
  logic          q_m1;
  logic          a_sign;
  logic          divisor_zero;
  logic [7:0]    cs;
  logic [CW-1:0] cnt;
  logic          busy;
  logic          done;
  logic          err;
  logic [7:0]    cs16;
  logic [3:0]    cnt16;
  logic          busy16;
  logic          done16;
  logic          err16;

  int checkCount = 0;
  int passCount  = 0;

  // One expected cycle: the strobes and counter we should see, the flags
  // we present to the DUT during that cycle, and the expected err level.
  typedef struct {
    logic [7:0] cs;
    int         cnt;
    bit         q0;
    bit         qm1;
    bit         asign;
    bit         dz;
    bit         err;
  } step_t;

  step_t plan[$];

  int doneAt, nAdd, nSub, nShift, nCorr;

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  alu_ctrl_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .opcode       (opcode),
    .q0           (q0),
    .q_m1         (q_m1),
    .a_sign       (a_sign),
    .divisor_zero (divisor_zero),
    .cs           (cs),
    .cnt          (cnt),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  alu_ctrl_seq #(.WIDTH(16)) dut16 (
    .clk          (clk),
    .rst          (rst),
    .start        (start16),
    .opcode       (opcode),
    .q0           (q0),
    .q_m1         (q_m1),
    .a_sign       (a_sign),
    .divisor_zero (divisor_zero),
    .cs           (cs16),
    .cnt          (cnt16),
    .busy         (busy16),
    .done         (done16),
    .err          (err16)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Append one expected cycle; flags not given explicitly are random.
  function automatic void pushStep(input logic [7:0] c, input int n, input bit e,
                                   input int qp, input int as, input int dz);
    step_t s;
    s.cs    = c;
    s.cnt   = n;
    s.err   = e;
    s.q0    = (qp < 0) ? 1'($urandom_range(0, 1)) : qp[1];
    s.qm1   = (qp < 0) ? 1'($urandom_range(0, 1)) : qp[0];
    s.asign = (as < 0) ? 1'($urandom_range(0, 1)) : as[0];
    s.dz    = (dz < 0) ? 1'($urandom_range(0, 1)) : dz[0];
    plan.push_back(s);
  endfunction

  // Expand an operation into its cycle list straight from the operation
  // rules. forceBits < 0 means random decisions; otherwise it fixes the
  // Booth pair (multiply) or the A sign bit (divide) at every decision.
  function automatic void buildPlan(input logic [1:0] op, input int forceBits, input bit dz);
    int pair;
    int sgn;
    plan.delete();
    pushStep(CS_LOAD, 0, 1'b0, -1, -1, int'(dz));
`ifdef DIV0_CHECK_EN
    if (op == 2'b11 && dz) begin
      pushStep(CS_DONE, 0, 1'b1, -1, -1, -1);
      return;
    end
`endif
    case (op)
      2'b00: begin
        pushStep(CS_ADD, 0, 1'b0, -1, -1, -1);
        pushStep(CS_OUTPUT, 0, 1'b0, -1, -1, -1);
        pushStep(CS_DONE, 0, 1'b0, -1, -1, -1);
      end
      2'b01: begin
        pushStep(CS_SUB, 0, 1'b0, -1, -1, -1);
        pushStep(CS_OUTPUT, 0, 1'b0, -1, -1, -1);
        pushStep(CS_DONE, 0, 1'b0, -1, -1, -1);
      end
      2'b10: begin
        for (int i = 0; i < W; i++) begin
          pair = (forceBits < 0) ? int'($urandom_range(0, 3)) : (forceBits & 3);
          pushStep(CS_DECIDE, i, 1'b0, pair, -1, -1);
          if (pair == 2) pushStep(CS_SUB, i, 1'b0, -1, -1, -1);
          if (pair == 1) pushStep(CS_ADD, i, 1'b0, -1, -1, -1);
          pushStep(CS_SHIFT, i, 1'b0, -1, -1, -1);
        end
        pushStep(CS_OUTPUT, W - 1, 1'b0, -1, -1, -1);
        pushStep(CS_DONE, W - 1, 1'b0, -1, -1, -1);
      end
      default: begin
        for (int i = 0; i < W; i++) begin
          sgn = (forceBits < 0) ? int'($urandom_range(0, 1)) : (forceBits & 1);
          pushStep(CS_SHIFT, i, 1'b0, -1, sgn, -1);
          pushStep((sgn == 1) ? CS_ADD : CS_SUB, i, 1'b0, -1, -1, -1);
        end
        sgn = (forceBits < 0) ? int'($urandom_range(0, 1)) : (forceBits & 1);
        pushStep(CS_DECIDE, W - 1, 1'b0, -1, sgn, -1);
        if (sgn == 1) pushStep(CS_CORRECT, W - 1, 1'b0, -1, -1, -1);
        pushStep(CS_OUTPUT, W - 1, 1'b0, -1, -1, -1);
        pushStep(CS_DONE, W - 1, 1'b0, -1, -1, -1);
      end
    endcase
  endfunction

  // Run one operation from idle and compare every cycle plus the idle
  // cycle after it. With noise set, start and opcode toggle randomly while
  // busy, which must have no effect. Called and returns on a falling edge.
  task automatic applyStimulus(input string name, input logic [1:0] op,
                               input int forceBits, input bit dz, input bit noise);
    step_t last;
    buildPlan(op, forceBits, dz);
    doneAt = 0; nAdd = 0; nSub = 0; nShift = 0; nCorr = 0;
    start  = 1'b1;
    opcode = op;
    foreach (plan[k]) begin
      @(posedge clk);
      #1;
      start        = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      opcode       = noise ? 2'($urandom_range(0, 3)) : op;
      q0           = plan[k].q0;
      q_m1         = plan[k].qm1;
      a_sign       = plan[k].asign;
      divisor_zero = plan[k].dz;
      @(negedge clk);
      checkOutput($sformatf("%s cs c%0d", name, k + 1), 32'(cs), 32'(plan[k].cs));
      checkOutput($sformatf("%s busy c%0d", name, k + 1), 32'(busy), 32'd1);
      checkOutput($sformatf("%s done c%0d", name, k + 1), 32'(done),
                  32'(plan[k].cs == CS_DONE));
      checkOutput($sformatf("%s cnt c%0d", name, k + 1), 32'(cnt), 32'(plan[k].cnt));
      checkOutput($sformatf("%s err c%0d", name, k + 1), 32'(err), 32'(plan[k].err));
      if (done && doneAt == 0) doneAt = k + 1;
      if (cs[1]) nAdd++;
      if (cs[2]) nSub++;
      if (cs[3]) nShift++;
      if (cs[4]) nCorr++;
    end
    last = plan[plan.size() - 1];
    @(posedge clk);
    #1;
    start  = 1'b0;
    opcode = 2'b00;
    @(negedge clk);
    checkOutput({name, " idle cs"}, 32'(cs), 32'd0);
    checkOutput({name, " idle busy"}, 32'(busy), 32'd0);
    checkOutput({name, " idle done"}, 32'(done), 32'd0);
    checkOutput({name, " idle cnt"}, 32'(cnt), 32'(last.cnt));
    checkOutput({name, " idle err"}, 32'(err), 32'(last.err));
  endtask

  // Start a divide, then pull reset low partway through and confirm the
  // outputs clear at once, no done shows up, and the block comes back idle.
  task automatic applyAbort();
    start  = 1'b1;
    opcode = 2'b11;
    divisor_zero = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    checkOutput("abort busy before", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("abort cs", 32'(cs), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort cnt", 32'(cnt), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("abort done held", 32'(done), 32'd0);
    checkOutput("abort cs held", 32'(cs), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort cs after", 32'(cs), 32'd0);
    checkOutput("abort busy after", 32'(busy), 32'd0);
  endtask

  // WIDTH=16 multiply with the Booth pair held at 00: shift-only path.
  task automatic applyWide();
    int cyc;
    int shifts;
    cyc = 0;
    shifts = 0;
    q0 = 1'b0;
    q_m1 = 1'b0;
    opcode = 2'b10;
    start16 = 1'b1;
    while (cyc < 60) begin
      @(posedge clk);
      #1;
      start16 = 1'b0;
      cyc++;
      @(negedge clk);
      if (cs16[3]) shifts++;
      if (done16) break;
    end
    checkOutput("w16 done cycle", 32'(cyc), 32'd35);
    checkOutput("w16 shifts", 32'(shifts), 32'd16);
    checkOutput("w16 cnt", 32'(cnt16), 32'd15);
    @(negedge clk);
    checkOutput("w16 busy after", 32'(busy16), 32'd0);
    opcode = 2'b00;
  endtask

  // Main sequence: reset, directed operations, abort, wide case, random.
  initial begin
    rst = 1'b0;
    start = 1'b0;
    start16 = 1'b0;
    opcode = 2'b00;
    q0 = 1'b0;
    q_m1 = 1'b0;
    a_sign = 1'b0;
    divisor_zero = 1'b0;
    #22;
    checkOutput("reset cs", 32'(cs), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset cnt", 32'(cnt), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    applyStimulus("add", 2'b00, -1, 1'b0, 1'b0);
    checkOutput("add latency", 32'(doneAt), 32'd4);
    applyStimulus("sub", 2'b01, -1, 1'b0, 1'b0);
    checkOutput("sub latency", 32'(doneAt), 32'd4);

    applyStimulus("mul01", 2'b10, 1, 1'b0, 1'b0);
    checkOutput("mul01 latency", 32'(doneAt), 32'd27);
    checkOutput("mul01 adds", 32'(nAdd), 32'd8);
    checkOutput("mul01 shifts", 32'(nShift), 32'd8);
    applyStimulus("mul00", 2'b10, 0, 1'b0, 1'b0);
    checkOutput("mul00 latency", 32'(doneAt), 32'd19);
    checkOutput("mul00 adds", 32'(nAdd + nSub), 32'd0);

    applyStimulus("div0s", 2'b11, 0, 1'b0, 1'b0);
    checkOutput("div pos latency", 32'(doneAt), 32'd20);
    checkOutput("div pos subs", 32'(nSub), 32'd8);
    checkOutput("div pos corr", 32'(nCorr), 32'd0);
    applyStimulus("div1s", 2'b11, 1, 1'b0, 1'b0);
    checkOutput("div neg latency", 32'(doneAt), 32'd21);
    checkOutput("div neg adds", 32'(nAdd), 32'd8);
    checkOutput("div neg corr", 32'(nCorr), 32'd1);

    applyStimulus("mulnoise", 2'b10, -1, 1'b0, 1'b1);

    applyAbort();
    applyStimulus("add after abort", 2'b00, -1, 1'b0, 1'b0);
    checkOutput("add after abort latency", 32'(doneAt), 32'd4);

`ifdef DIV0_CHECK_EN
    applyStimulus("divz", 2'b11, -1, 1'b1, 1'b0);
    checkOutput("divz latency", 32'(doneAt), 32'd2);
    checkOutput("divz addsub", 32'(nAdd + nSub), 32'd0);
`else
    applyStimulus("divz", 2'b11, 0, 1'b1, 1'b0);
    checkOutput("divz latency", 32'(doneAt), 32'd20);
`endif

    applyWide();

    for (int r = 0; r < 25; r++) begin
      applyStimulus($sformatf("rnd%0d", r), 2'($urandom_range(0, 3)), -1,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
